// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared repeat-FSM state encoding and a width helper for the
//            debounce_bank push-button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        S_RELEASED = 2'd0,
        S_PRESSED  = 2'd1,
        S_REPEAT   = 2'd2
    } rpt_state_t;

    // Bits needed to hold values 0 .. value-1, never less than one.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One button: 2-flop synchroniser, stability filter, auto-repeat
//            FSM and registered press/release/step pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic rel_pulse,
    output logic step_pulse
);

    localparam int c_stb_w = clog2w(STABLE_CYCLES);
    localparam int c_rpt_w = clog2w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [c_stb_w-1:0] c_stb_last   = c_stb_w'(STABLE_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_delay_last = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_per_last   = c_rpt_w'(REPEAT_PERIOD - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_stb_w-1:0] r_stb_cnt;
    logic               r_level;
    logic               r_press;
    logic               r_rel;
    logic               r_step;
    rpt_state_t         r_state;
    rpt_state_t         w_state_nxt;
    logic [c_rpt_w-1:0] r_rpt_cnt;
    logic [c_rpt_w-1:0] w_rpt_nxt;
    logic               w_rpt_fire;
    logic               w_diff;
    logic               w_accept;
    logic               w_press_acc;
    logic               w_rel_acc;

    assign w_diff      = r_sync2 ^ r_level;
    assign w_accept    = w_diff && (r_stb_cnt == c_stb_last);
    assign w_press_acc = w_accept & ~r_level;
    assign w_rel_acc   = w_accept &  r_level;

    // Release is checked first so it suppresses a repeat due on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt_cnt;
        w_rpt_fire  = 1'b0;
        case (r_state)
            S_RELEASED: begin
                w_rpt_nxt = '0;
                if (w_press_acc) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if (w_rel_acc) begin
                    w_state_nxt = S_RELEASED;
                    w_rpt_nxt   = '0;
                end else if (r_rpt_cnt == c_delay_last) begin
                    w_rpt_nxt = '0;
                    if (repeat_en) begin
                        w_rpt_fire  = 1'b1;
                        w_state_nxt = S_REPEAT;
                    end
                end else begin
                    w_rpt_nxt = r_rpt_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (w_rel_acc) begin
                    w_state_nxt = S_RELEASED;
                    w_rpt_nxt   = '0;
                end else if (!repeat_en) begin
                    w_state_nxt = S_PRESSED;
                    w_rpt_nxt   = '0;
                end else if (r_rpt_cnt == c_per_last) begin
                    w_rpt_fire = 1'b1;
                    w_rpt_nxt  = '0;
                end else begin
                    w_rpt_nxt = r_rpt_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RELEASED;
                w_rpt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stb_cnt <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_rel     <= 1'b0;
            r_step    <= 1'b0;
            r_state   <= S_RELEASED;
            r_rpt_cnt <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            if (!w_diff || w_accept) begin
                r_stb_cnt <= '0;
            end else begin
                r_stb_cnt <= r_stb_cnt + 1'b1;
            end
            if (w_accept) r_level <= ~r_level;
            r_press   <= w_press_acc;
            r_rel     <= w_rel_acc;
            r_step    <= w_press_acc | w_rpt_fire;
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_nxt;
        end
    end

    assign level       = r_level;
    assign press_pulse = r_press;
    assign rel_pulse   = r_rel;
    assign step_pulse  = r_step;

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Purpose  : CH independent push-button conditioners with optional repeat.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int CH            = 4,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [CH-1:0] btn_in,
    input  logic [CH-1:0] repeat_en,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] rel_pulse,
    output logic [CH-1:0] step_pulse
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .n_reset     (n_reset),
            .btn_in      (btn_in[i]),
            .repeat_en   (repeat_en[i]),
            .level       (level[i]),
            .press_pulse (press_pulse[i]),
            .rel_pulse   (rel_pulse[i]),
            .step_pulse  (step_pulse[i])
        );
    end

endmodule
`default_nettype wire
